irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
- Interrupt controller sitting directly downstream of the timer block.
- Consumes the timer's timeout_o and other peripheral event lines, edge-detects them and latches them into a pending register.
- Masks pending events with per-source enables and raises a single CPU interrupt with the highest-priority source ID.
- Sits on the same peripheral bus (sel/wr_en/rd_en/addr/wdata/rdata) as the timer.

Parameters:
- NSRC, 8, number of interrupt sources (1..32); source 0 = highest priority, typically timer timeout_o.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset; synchronous, active-low.
- sel  input  1  block selected on peripheral bus.
- wr_en  input  1  write strobe, qualified by sel.
- rd_en  input  1  read strobe, qualified by sel.
- addr  input  3  register select.
- wdata  input  32  write data.
- rdata  output  32  registered read data.
- src_i  input  NSRC  event lines; bit0 = timer timeout_o.
- irq_o  output  1  interrupt request to CPU, registered.
- irq_id_o  output  5  ID of highest-priority active source, registered; 0 when irq_o=0.

Behaviour:
- Register map (word index addr):
  - 0 ENABLE: RW, bits[NSRC-1:0].
  - 1 PENDING: read; W1C on write.
  - 2 ACTIVE: RO, PENDING & ENABLE.
  - 3 CLAIM: read returns {valid at bit31, 26'b0, id[4:0]}; side effect clears PENDING[id] when valid. Writes ignored.
  - 4 SWSET: write-1-to-set PENDING bits; reads 0.
  - 5 GCTRL: RW, bit0 = global enable (GEN).
  - 6, 7: read 0, writes ignored.
- Bits at or above NSRC read 0 and ignore writes in all registers.
- Reset: ENABLE=0, PENDING=0, GEN=0, src_q=0, rdata=0, irq_o=0, irq_id_o=0.
- Edge detect: src_q <= src_i each cycle; rise = src_i & ~src_q.
  - A level held high sets PENDING only once.
  - A source high coming out of reset produces an edge in the first cycle after reset.
- PENDING next-state per bit: (PENDING & ~clr) | rise | swset.
  - clr = W1C bit or claim-clear.
  - Set wins over clear in the same cycle, so no event is lost.
- Claim: on sel&rd_en&addr==3, id = lowest-index set bit of ACTIVE (sampled from current-cycle registers).
  - rdata gets {1,id} one cycle later; PENDING[id] clears on the same edge.
  - If ACTIVE==0: rdata=0, nothing cleared.
- Reads: registered, 1-cycle latency; rdata holds its value when not reading.
- Interrupt output: irq_o <= GEN & |ACTIVE; irq_id_o <= priority-encode(ACTIVE), 0 if none.
  - Latency from src_i rise to irq_o = 2 cycles (1 to PENDING, 1 to output register).
- Disabling a source (ENABLE bit 0) does not clear its PENDING bit; re-enabling raises irq_o if still pending.
- GEN=0 forces irq_o=0 but PENDING keeps accumulating.
- Reset mid-operation: all state returns to reset values on the next edge; pending events are discarded.

Optional Feature:
- Macro IRQ_CTRL_SYNC_EN.
- Defined: each src_i bit passes through a 2-flop synchronizer before the edge-detect flop, for asynchronous sources. src_i-to-irq_o latency becomes 4 cycles. Synchronizer flops reset to 0.
- Undefined: src_i is used directly (same-clock sources only); latency 2 cycles.

Test Plan:
- Reset, then read all 8 addresses -> rdata=0 for each; irq_o=0, irq_id_o=0.
- ENABLE=0x01, GCTRL=1, pulse src_i[0] 1 cycle -> PENDING=0x01, irq_o=1 and irq_id_o=0 exactly 2 cycles after the pulse; read CLAIM -> 0x80000000, PENDING=0, irq_o=0 two cycles later.
- ENABLE=0xFF, GCTRL=1, raise src_i[5] and src_i[2] together -> irq_id_o=2; CLAIM returns 0x80000002, then irq_id_o=5; second CLAIM returns 0x80000005; third CLAIM returns 0x00000000.
- Hold src_i[1] high 20 cycles -> PENDING[1] set once; W1C 0x02 at cycle 10 -> PENDING[1]=0 and stays 0.
- W1C PENDING=0x01 in the same cycle as a src_i[0] rising edge -> PENDING[0]=1 afterwards (set wins).
- ENABLE=0, SWSET=0x08 -> PENDING=0x08, ACTIVE=0, irq_o=0; then ENABLE=0x08 -> irq_o=1, irq_id_o=3; GCTRL=0 -> irq_o=0, PENDING still 0x08.

Source files
------------

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl -- interrupt controller downstream of the timer block.
//
// Edge-detects the event lines on src_i (bit 0 is normally the timer's
// timeout_o) and latches each rising edge into PENDING. ACTIVE is
// PENDING & ENABLE. One registered CPU interrupt is raised together with the
// ID of the highest-priority active source (lowest index wins).
//
// Register map (word index addr):
//   0 ENABLE  RW   per-source enables
//   1 PENDING R    write-1-to-clear
//   2 ACTIVE  RO   PENDING & ENABLE
//   3 CLAIM   R    {valid, 26'b0, id}; a valid read clears PENDING[id]
//   4 SWSET   W    write-1-to-set PENDING, reads 0
//   5 GCTRL   RW   bit0 = global interrupt enable
//   6,7       read 0, writes ignored
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   sel, wr_en, rd_en  peripheral bus strobes (wr_en/rd_en qualified by sel)
//   addr, wdata        register index and write data
//   rdata              registered read data (1-cycle latency, holds when idle)
//   src_i              event lines
//   irq_o, irq_id_o    registered interrupt request and source ID
//
// Optional build macro IRQ_CTRL_SYNC_EN: routes every src_i bit through a
// 2-flop synchronizer ahead of the edge-detect flop, for asynchronous
// sources. src_i-to-irq_o latency grows from 2 to 4 cycles.
// ---------------------------------------------------------------------------
module irq_ctrl #(
    parameter int unsigned NSRC = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            sel,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic [2:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic [NSRC-1:0] src_i,
    output logic            irq_o,
    output logic [4:0]      irq_id_o
);

    typedef enum logic [2:0] {
        REG_ENABLE  = 3'd0,
        REG_PENDING = 3'd1,
        REG_ACTIVE  = 3'd2,
        REG_CLAIM   = 3'd3,
        REG_SWSET   = 3'd4,
        REG_GCTRL   = 3'd5,
        REG_RSVD6   = 3'd6,
        REG_RSVD7   = 3'd7
    } reg_e;

    logic [NSRC-1:0] enable_q,  enable_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic            gen_q,     gen_d;
    logic [NSRC-1:0] src_q;
    logic [31:0]     rdata_q,   rdata_d;
    logic            irq_q,     irq_d;
    logic [4:0]      irq_id_q,  irq_id_d;

    logic [NSRC-1:0] src_s;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] active;
    logic [NSRC-1:0] active_low;
    logic [4:0]      active_id;
    logic            any_active;
    logic            bus_wr;
    logic            bus_rd;
    reg_e            reg_sel;

    // Only wdata[NSRC-1:0] and wdata[0] carry meaning; fold the rest here.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

`ifdef IRQ_CTRL_SYNC_EN
    logic [NSRC-1:0] sync1_q;
    logic [NSRC-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src_i;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = src_i;
`endif

    assign rise       = src_s & ~src_q;
    assign active     = pending_q & enable_q;
    assign any_active = |active;
    // Isolate the lowest set bit: this is the claimed source as a one-hot mask.
    assign active_low = active & (~active + 1'b1);
    assign bus_wr     = sel & wr_en;
    assign bus_rd     = sel & rd_en;
    assign reg_sel    = reg_e'(addr);

    // Priority encoder, lowest index wins; 0 when nothing is active.
    always_comb begin
        active_id = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (active[NSRC-1-i]) begin
                active_id = 5'(NSRC-1-i);
            end
        end
    end

    always_comb begin
        logic [NSRC-1:0] clr;
        logic [NSRC-1:0] swset;

        enable_d  = enable_q;
        gen_d     = gen_q;
        rdata_d   = rdata_q;
        clr       = '0;
        swset     = '0;

        if (bus_wr) begin
            unique case (reg_sel)
                REG_ENABLE:  enable_d = wdata[NSRC-1:0];
                REG_PENDING: clr      = wdata[NSRC-1:0];
                REG_SWSET:   swset    = wdata[NSRC-1:0];
                REG_GCTRL:   gen_d    = wdata[0];
                default:     ;
            endcase
        end

        if (bus_rd) begin
            unique case (reg_sel)
                REG_ENABLE:  rdata_d = 32'(enable_q);
                REG_PENDING: rdata_d = 32'(pending_q);
                REG_ACTIVE:  rdata_d = 32'(active);
                REG_CLAIM:   rdata_d = any_active ? {1'b1, 26'b0, active_id} : '0;
                REG_GCTRL:   rdata_d = {31'b0, gen_q};
                default:     rdata_d = '0;
            endcase
            if (reg_sel == REG_CLAIM) begin
                clr = clr | active_low;
            end
        end

        // Set terms applied after clear so a coincident event is never lost.
        pending_d = (pending_q & ~clr) | rise | swset;

        irq_d    = gen_q & any_active;
        irq_id_d = (gen_q & any_active) ? active_id : '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            enable_q  <= '0;
            pending_q <= '0;
            gen_q     <= 1'b0;
            src_q     <= '0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            enable_q  <= enable_d;
            pending_q <= pending_d;
            gen_q     <= gen_d;
            src_q     <= src_s;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
            irq_id_q  <= irq_id_d;
        end
    end

    assign rdata    = rdata_q;
    assign irq_o    = irq_q;
    assign irq_id_o = irq_id_q;

endmodule
